// File: rtl/swir_pll_lock_supervisor.sv
// rtl/swir_pll_lock_supervisor.sv - SWIR PLL lock supervisor with retry, fault latch and staged domain-reset release
// Define SWIR_PLL_SUP_LOSS_CNT_EN to add the saturating loss_count port.
module swir_pll_lock_supervisor #(
   parameter int LOCK_STABLE_CYCLES  = 1000,
   parameter int LOCK_TIMEOUT_CYCLES = 50000,
   parameter int PLL_RST_CYCLES      = 16,
   parameter int MAX_RETRIES         = 3,
   parameter int STAGGER_CYCLES      = 8
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       retry_req,
   output logic       pll_rst,
   output logic [2:0] domain_rst,
   output logic       clocks_ready,
   output logic       fault,
   output logic [1:0] retry_count
`ifdef SWIR_PLL_SUP_LOSS_CNT_EN
   ,
   output logic [7:0] loss_count
`endif
);

   localparam int SW = (LOCK_STABLE_CYCLES  > 1) ? $clog2(LOCK_STABLE_CYCLES)  : 1;
   localparam int TW = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
   localparam int RW = (PLL_RST_CYCLES      > 1) ? $clog2(PLL_RST_CYCLES)      : 1;
   localparam int GW = (STAGGER_CYCLES      > 1) ? $clog2(STAGGER_CYCLES)      : 1;

   localparam logic [SW-1:0] STABLE_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [RW-1:0] PLL_RST_LAST = RW'(PLL_RST_CYCLES - 1);
   localparam logic [GW-1:0] STAGGER_LAST = GW'(STAGGER_CYCLES - 1);
   localparam logic [1:0]    RETRY_MAX    = 2'(MAX_RETRIES);

   typedef enum logic [2:0] {
      PLL_RESET = 3'd0,
      WAIT_LOCK = 3'd1,
      STABILIZE = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4,
      FAULT     = 3'd5
   } state_t;

   state_t        state;
   logic          sync_q1;
   logic          locked_s;
   logic [RW-1:0] rst_cnt;
   logic [TW-1:0] tmo_cnt;
   logic [SW-1:0] stb_cnt;
   logic [GW-1:0] stg_cnt;
   logic          tmo_hit;
   logic          retries_spent;

   always_ff @(posedge refclk) begin
      if (rst) begin
         sync_q1  <= 1'b0;
         locked_s <= 1'b0;
      end else begin
         sync_q1  <= pll_locked;
         locked_s <= sync_q1;
      end
   end

   always_comb begin
      tmo_hit       = (tmo_cnt == TIMEOUT_LAST);
      retries_spent = (retry_count == RETRY_MAX);
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         state        <= PLL_RESET;
         pll_rst      <= 1'b1;
         domain_rst   <= 3'b111;
         clocks_ready <= 1'b0;
         fault        <= 1'b0;
         retry_count  <= 2'd0;
         rst_cnt      <= '0;
         tmo_cnt      <= '0;
         stb_cnt      <= '0;
         stg_cnt      <= '0;
      end else begin
         case (state)
            PLL_RESET: begin
               if (rst_cnt == PLL_RST_LAST) begin
                  state   <= WAIT_LOCK;
                  pll_rst <= 1'b0;
                  tmo_cnt <= '0;
               end else begin
                  rst_cnt <= rst_cnt + 1'b1;
               end
            end

            // Timeout wins over a lock arriving in the same cycle.
            WAIT_LOCK: begin
               if (tmo_hit) begin
                  pll_rst <= 1'b1;
                  rst_cnt <= '0;
                  if (retries_spent) begin
                     state <= FAULT;
                     fault <= 1'b1;
                  end else begin
                     state       <= PLL_RESET;
                     retry_count <= retry_count + 1'b1;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
                  if (locked_s) begin
                     state   <= STABILIZE;
                     stb_cnt <= '0;
                  end
               end
            end

            // The timeout keeps running here so a chattering lock still retries.
            STABILIZE: begin
               if (tmo_hit) begin
                  pll_rst <= 1'b1;
                  rst_cnt <= '0;
                  if (retries_spent) begin
                     state <= FAULT;
                     fault <= 1'b1;
                  end else begin
                     state       <= PLL_RESET;
                     retry_count <= retry_count + 1'b1;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
                  if (!locked_s) begin
                     state <= WAIT_LOCK;
                  end else if (stb_cnt == STABLE_LAST) begin
                     state      <= RELEASE;
                     domain_rst <= 3'b110;
                     stg_cnt    <= '0;
                  end else begin
                     stb_cnt <= stb_cnt + 1'b1;
                  end
               end
            end

            RELEASE: begin
               if (!locked_s) begin
                  state        <= PLL_RESET;
                  pll_rst      <= 1'b1;
                  domain_rst   <= 3'b111;
                  clocks_ready <= 1'b0;
                  retry_count  <= 2'd0;
                  rst_cnt      <= '0;
               end else if (stg_cnt == STAGGER_LAST) begin
                  stg_cnt <= '0;
                  if (domain_rst[1]) begin
                     domain_rst <= 3'b100;
                  end else begin
                     state        <= RUN;
                     domain_rst   <= 3'b000;
                     clocks_ready <= 1'b1;
                     retry_count  <= 2'd0;
                  end
               end else begin
                  stg_cnt <= stg_cnt + 1'b1;
               end
            end

            RUN: begin
               if (!locked_s) begin
                  state        <= PLL_RESET;
                  pll_rst      <= 1'b1;
                  domain_rst   <= 3'b111;
                  clocks_ready <= 1'b0;
                  retry_count  <= 2'd0;
                  rst_cnt      <= '0;
               end
            end

            FAULT: begin
               if (retry_req) begin
                  state       <= PLL_RESET;
                  fault       <= 1'b0;
                  retry_count <= 2'd0;
                  rst_cnt     <= '0;
               end
            end

            default: begin
               state        <= PLL_RESET;
               pll_rst      <= 1'b1;
               domain_rst   <= 3'b111;
               clocks_ready <= 1'b0;
               fault        <= 1'b0;
               rst_cnt      <= '0;
            end
         endcase
      end
   end

`ifdef SWIR_PLL_SUP_LOSS_CNT_EN
   logic lock_lost;

   always_comb begin
      lock_lost = ((state == RELEASE) || (state == RUN)) && !locked_s;
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         loss_count <= 8'd0;
      end else if (lock_lost && (loss_count != 8'hff)) begin
         loss_count <= loss_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_swir_pll_lock_supervisor.sv
// tb/tb_swir_pll_lock_supervisor.sv - self-checking bench for swir_pll_lock_supervisor
// Covers the optional loss_count port when SWIR_PLL_SUP_LOSS_CNT_EN is defined.
module tb_swir_pll_lock_supervisor;

   localparam int LSC = 10;
   localparam int LTC = 100;
   localparam int PRC = 4;
   localparam int MXR = 2;
   localparam int SGC = 3;

   logic       refclk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_locked = 1'b0;
   logic       retry_req = 1'b0;
   logic       pll_rst;
   logic [2:0] domain_rst;
   logic       clocks_ready;
   logic       fault;
   logic [1:0] retry_count;
`ifdef SWIR_PLL_SUP_LOSS_CNT_EN
   logic [7:0] loss_count;
`endif

   int errors = 0;
   int checks = 0;

   swir_pll_lock_supervisor #(
      .LOCK_STABLE_CYCLES (LSC),
      .LOCK_TIMEOUT_CYCLES(LTC),
      .PLL_RST_CYCLES     (PRC),
      .MAX_RETRIES        (MXR),
      .STAGGER_CYCLES     (SGC)
   ) dut (
      .refclk      (refclk),
      .rst         (rst),
      .pll_locked  (pll_locked),
      .retry_req   (retry_req),
      .pll_rst     (pll_rst),
      .domain_rst  (domain_rst),
      .clocks_ready(clocks_ready),
      .fault       (fault),
      .retry_count (retry_count)
`ifdef SWIR_PLL_SUP_LOSS_CNT_EN
      ,
      .loss_count  (loss_count)
`endif
   );

   always #5 refclk = ~refclk;

   // Reference model: mode 0 reset, 1 waiting, 2 stabilising, 3 released/running, 4 fault.
   // Timing is tracked as edge timestamps rather than per-state counters.
   int m_mode = 0;
   int m_tmode = 0;
   int m_twait = 0;
   int m_retries = 0;
   int m_losses = 0;
   int ncyc = 0;
   bit lhist[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at t=%0t: actual=%0h required=%0h", name, $time, act, exp);
      end
   endtask

   task automatic model_edge();
      int  e;
      bit  ls;
      ncyc++;
      if (rst) begin
         m_mode    = 0;
         m_tmode   = ncyc;
         m_retries = 0;
         m_losses  = 0;
         lhist     = {1'b0, 1'b0};
         return;
      end
      ls = lhist[0];
      void'(lhist.pop_front());
      lhist.push_back(pll_locked);
      e = ncyc - m_tmode;
      case (m_mode)
         0: if (e == PRC) begin
               m_mode = 1; m_tmode = ncyc; m_twait = ncyc;
            end
         1, 2: begin
            if (ncyc - m_twait == LTC) begin
               if (m_retries == MXR) m_mode = 4;
               else begin m_retries++; m_mode = 0; end
               m_tmode = ncyc;
            end else if (m_mode == 1 && ls) begin
               m_mode = 2; m_tmode = ncyc;
            end else if (m_mode == 2 && !ls) begin
               m_mode = 1; m_tmode = ncyc;
            end else if (m_mode == 2 && e == LSC) begin
               m_mode = 3; m_tmode = ncyc;
            end
         end
         3: begin
            if (!ls) begin
               m_mode = 0; m_tmode = ncyc; m_retries = 0;
               if (m_losses < 255) m_losses++;
            end else if (e == 2 * SGC) begin
               m_retries = 0;
            end
         end
         default: if (retry_req) begin
               m_mode = 0; m_tmode = ncyc; m_retries = 0;
            end
      endcase
   endtask

   function automatic logic [7:0] model_out();
      logic       pr, cr, f;
      logic [2:0] dr;
      int         e;
      e  = ncyc - m_tmode;
      pr = (m_mode == 0) || (m_mode == 4);
      f  = (m_mode == 4);
      if (m_mode == 3) dr = (e < SGC) ? 3'b110 : ((e < 2 * SGC) ? 3'b100 : 3'b000);
      else dr = 3'b111;
      cr = (m_mode == 3) && (e >= 2 * SGC);
      return {pr, dr, cr, f, 2'(m_retries)};
   endfunction

   task automatic step();
      @(posedge refclk);
      model_edge();
      #1;
      check("model_outputs", 32'({pll_rst, domain_rst, clocks_ready, fault, retry_count}), 32'(model_out()));
`ifdef SWIR_PLL_SUP_LOSS_CNT_EN
      check("model_loss_count", 32'(loss_count), 32'(m_losses));
`endif
   endtask

   typedef struct {
      bit       rst;
      bit       pl;
      bit       rr;
      int       n;
      bit       e_pr;
      bit [2:0] e_dr;
      bit       e_cr;
      bit       e_f;
      bit [1:0] e_rc;
      int       e_loss;
   } vec_t;

   vec_t tbl[16];

   initial begin
      int  k;
      int  hold;
      bit  released;

      lhist = {1'b0, 1'b0};
      // Nominal acquisition, lock loss in RUN, then reset during the staged release.
      tbl[0]  = '{1, 0, 0,  2, 1, 3'b111, 0, 0, 2'd0, 0};
      tbl[1]  = '{0, 0, 0,  3, 1, 3'b111, 0, 0, 2'd0, 0};
      tbl[2]  = '{0, 0, 0,  1, 0, 3'b111, 0, 0, 2'd0, 0};
      tbl[3]  = '{0, 0, 0, 19, 0, 3'b111, 0, 0, 2'd0, 0};
      tbl[4]  = '{0, 1, 0, 12, 0, 3'b111, 0, 0, 2'd0, 0};
      tbl[5]  = '{0, 1, 0,  1, 0, 3'b110, 0, 0, 2'd0, 0};
      tbl[6]  = '{0, 1, 0,  2, 0, 3'b110, 0, 0, 2'd0, 0};
      tbl[7]  = '{0, 1, 0,  1, 0, 3'b100, 0, 0, 2'd0, 0};
      tbl[8]  = '{0, 1, 0,  2, 0, 3'b100, 0, 0, 2'd0, 0};
      tbl[9]  = '{0, 1, 0,  1, 0, 3'b000, 1, 0, 2'd0, 0};
      tbl[10] = '{0, 1, 0,  5, 0, 3'b000, 1, 0, 2'd0, 0};
      tbl[11] = '{0, 0, 0,  2, 0, 3'b000, 1, 0, 2'd0, 0};
      tbl[12] = '{0, 0, 0,  1, 1, 3'b111, 0, 0, 2'd0, 1};
      tbl[13] = '{0, 1, 0, 14, 0, 3'b111, 0, 0, 2'd0, 1};
      tbl[14] = '{0, 1, 0,  1, 0, 3'b110, 0, 0, 2'd0, 1};
      tbl[15] = '{1, 1, 0,  1, 1, 3'b111, 0, 0, 2'd0, 0};

      for (int i = 0; i < 16; i++) begin
         rst        = tbl[i].rst;
         pll_locked = tbl[i].pl;
         retry_req  = tbl[i].rr;
         repeat (tbl[i].n) step();
         check($sformatf("row%0d_pll_rst", i),      32'(pll_rst),      32'(tbl[i].e_pr));
         check($sformatf("row%0d_domain_rst", i),   32'(domain_rst),   32'(tbl[i].e_dr));
         check($sformatf("row%0d_clocks_ready", i), 32'(clocks_ready), 32'(tbl[i].e_cr));
         check($sformatf("row%0d_fault", i),        32'(fault),        32'(tbl[i].e_f));
         check($sformatf("row%0d_retry_count", i),  32'(retry_count),  32'(tbl[i].e_rc));
`ifdef SWIR_PLL_SUP_LOSS_CNT_EN
         check($sformatf("row%0d_loss_count", i),   32'(loss_count),   32'(tbl[i].e_loss));
`endif
      end

      // Chattering lock: 5 high / 5 low never releases and times out at cycle 100.
      rst = 1'b1; pll_locked = 1'b0; retry_req = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      k = 0;
      while (pll_rst && k < 20) begin step(); k++; end
      check("chatter_pll_rst_fall", 32'(pll_rst), 32'(0));
      released = 1'b0;
      for (int i = 1; i < LTC; i++) begin
         pll_locked = (((i - 1) % 10) < 5);
         step();
         if (domain_rst != 3'b111) released = 1'b1;
      end
      pll_locked = 1'b0;
      check("chatter_no_release", 32'(released), 32'(0));
      check("chatter_before_timeout", 32'(pll_rst), 32'(0));
      step();
      check("chatter_timeout_pll_rst", 32'(pll_rst), 32'(1));
      check("chatter_retry_count", 32'(retry_count), 32'(1));
      repeat (PRC - 1) step();
      check("chatter_pulse_held", 32'(pll_rst), 32'(1));
      step();
      check("chatter_pulse_end", 32'(pll_rst), 32'(0));

      // Lock never arrives: three timeouts latch FAULT, retry_req restarts.
      rst = 1'b1; pll_locked = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      k = 0;
      while (!fault && k < 400) begin step(); k++; end
      check("fault_latency", 32'(k), 32'(3 * (PRC + LTC)));
      check("fault_flag", 32'(fault), 32'(1));
      check("fault_pll_rst", 32'(pll_rst), 32'(1));
      check("fault_domain_rst", 32'(domain_rst), 32'(3'b111));
      check("fault_retry_count", 32'(retry_count), 32'(MXR));
      pll_locked = 1'b1;
      repeat (5) step();
      check("fault_ignores_lock", 32'(fault), 32'(1));
      retry_req = 1'b1;
      step();
      retry_req = 1'b0;
      check("retry_clears_fault", 32'(fault), 32'(0));
      check("retry_pll_rst", 32'(pll_rst), 32'(1));
      check("retry_clears_count", 32'(retry_count), 32'(0));
      repeat (PRC - 1) step();
      check("retry_pulse_held", 32'(pll_rst), 32'(1));
      step();
      check("retry_pulse_end", 32'(pll_rst), 32'(0));

      // Randomised lock behaviour, retry pulses and occasional resets.
      hold = 0;
      for (int c = 0; c < 4000; c++) begin
         if (hold == 0) begin
            if ($urandom_range(0, 3) != 0) pll_locked = ~pll_locked;
            if (pll_locked) hold = int'($urandom_range(1, 60));
            else if ($urandom_range(0, 7) == 0) hold = int'($urandom_range(80, 220));
            else hold = int'($urandom_range(1, 12));
         end
         hold--;
         retry_req = ($urandom_range(0, 15) == 0);
         rst       = ($urandom_range(0, 999) == 0);
         step();
      end
      retry_req = 1'b0;

`ifdef SWIR_PLL_SUP_LOSS_CNT_EN
      // Repeated lock losses saturate the counter.
      rst = 1'b1; pll_locked = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      for (int n = 0; n < 260; n++) begin
         pll_locked = 1'b1;
         k = 0;
         while (!clocks_ready && k < 300) begin step(); k++; end
         check("sat_reached_run", 32'(clocks_ready), 32'(1));
         pll_locked = 1'b0;
         repeat (3) step();
      end
      check("sat_loss_count", 32'(loss_count), 32'(255));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
